// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst scheduler.
// Holds the burst command opcodes, the 24-bit address layout
// {BA[1:0], Row[12:0], Col[8:0]} and the burst command payload.
package sdram_pkg;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned LEN_W   = 9;
  localparam int unsigned COL_W   = 9;
  localparam int unsigned ROW_W   = 13;
  localparam int unsigned BA_W    = 2;
  localparam int unsigned COL_LSB = 0;
  localparam int unsigned ROW_LSB = COL_LSB + COL_W;
  localparam int unsigned BA_LSB  = ROW_LSB + ROW_W;

  typedef enum logic [1:0] {
    OP_WR  = 2'd0,
    OP_RD  = 2'd1,
    OP_REF = 2'd2
  } cmd_op_t;

  // Address split into its SDRAM fields, MSB first.
  typedef struct packed {
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } sdram_addr_t;

  // One burst command as handed to the burst engine.
  typedef struct packed {
    cmd_op_t           op;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_cmd_t;

endpackage

// File: rtl/sdram_burst_chan.sv
// One transfer channel (write or read) of the burst scheduler.
// Tracks base address, remaining words, active flag and the last-burst flag,
// computes the next burst length so no burst crosses a BURST_LEN boundary.
// Ports: clk/rst; load + load_addr/load_length start or override a transfer;
// take advances the channel at the command handshake; done_in is the
// completion of this channel's burst; active/addr/len_c describe the next
// burst; done pulses when the final burst (or a zero-length load) completes.
module sdram_burst_chan
  import sdram_pkg::*;
#(
  parameter int unsigned BURST_LEN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_length,
  input  logic              take,
  input  logic              done_in,
  output logic              active,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] len_c,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BL   = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] MASK = BL - ADDR_W'(1);

  logic [ADDR_W-1:0] remain;
  logic              last_q;
  logic [ADDR_W-1:0] room;

  // Words left before the next BURST_LEN boundary, clipped to what remains.
  always_comb begin
    room  = BL - (addr & MASK);
    len_c = (remain < room) ? remain : room;
  end

  // A load always wins and drops the last flag of any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      addr   <= '0;
      remain <= '0;
      last_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        addr   <= load_addr;
        remain <= load_length;
        active <= (load_length != '0);
        last_q <= 1'b0;
        done   <= (load_length == '0);
      end else begin
        if (take) begin
          addr   <= addr + len_c;
          remain <= remain - len_c;
          active <= (remain != len_c);
          last_q <= (remain == len_c);
        end
        if (done_in) begin
          done   <= last_q;
          last_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_burst_sched.sv
// Burst scheduler sharing one SDRAM burst engine between write, read and
// auto-refresh. Issues one command at a time over cmd_valid/cmd_ready and
// waits for burst_done before deciding again.
// Ports: clk_sdram/rst; init_done gates grants and the refresh timer;
// wr_*/rd_* load transfers and report FIFO levels; cmd_* is the burst
// command; burst_done ends the accepted command; wr_done/rd_done pulse at
// the end of a transfer; busy = not IDLE; ref_overflow is sticky.
module sdram_burst_sched
  import sdram_pkg::*;
#(
  parameter int unsigned BURST_LEN    = 256,
  parameter int unsigned FIFO_DEPTH   = 512,
  parameter int unsigned RD_LOW_WM    = 128,
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned REF_URGENT   = 4
) (
  input  logic              clk_sdram,
  input  logic              rst,
  input  logic              init_done,
  input  logic              wr_load,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] wr_length,
  input  logic [9:0]        wr_fifo_cnt,
  input  logic              rd_load,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] rd_length,
  input  logic [9:0]        rd_fifo_cnt,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              burst_done,
  output logic              wr_done,
  output logic              rd_done,
  output logic              busy,
  output logic              ref_overflow
);

  localparam int unsigned       CNT_W    = $clog2(REF_INTERVAL);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REF_INTERVAL - 1);
  localparam logic [3:0]        PEND_MAX = 4'd8;
  localparam logic [ADDR_W-1:0] DEPTH    = ADDR_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t            state, state_n;
  cmd_op_t           op_q, grant_op;
  logic              grant, last_rd;
  logic              wr_active, rd_active;
  logic [ADDR_W-1:0] wr_cur, rd_cur, wr_len, rd_len;
  logic [ADDR_W-1:0] wr_cnt, rd_cnt, rd_space;
  logic              wr_ok, rd_ok, ref_ok, ref_urgent, rd_low;
  logic              hs, ref_tick;
  logic [CNT_W-1:0]  ref_cnt;
  logic [3:0]        pending;

  assign hs     = (state == ISSUE) && cmd_valid && cmd_ready;
  assign cmd_op = op_q;

  sdram_burst_chan #(.BURST_LEN(BURST_LEN)) u_wr (
    .clk(clk_sdram), .rst(rst), .load(wr_load), .load_addr(wr_addr),
    .load_length(wr_length), .take(hs && (op_q == OP_WR)),
    .done_in((state == WAIT) && burst_done && (op_q == OP_WR)),
    .active(wr_active), .addr(wr_cur), .len_c(wr_len), .done(wr_done)
  );

  sdram_burst_chan #(.BURST_LEN(BURST_LEN)) u_rd (
    .clk(clk_sdram), .rst(rst), .load(rd_load), .load_addr(rd_addr),
    .load_length(rd_length), .take(hs && (op_q == OP_RD)),
    .done_in((state == WAIT) && burst_done && (op_q == OP_RD)),
    .active(rd_active), .addr(rd_cur), .len_c(rd_len), .done(rd_done)
  );

  // Eligibility; read space clamps at zero if the FIFO reports overfull.
  always_comb begin
    wr_cnt     = ADDR_W'(wr_fifo_cnt);
    rd_cnt     = ADDR_W'(rd_fifo_cnt);
    rd_space   = (rd_cnt >= DEPTH) ? '0 : DEPTH - rd_cnt;
    wr_ok      = wr_active && (wr_cnt >= wr_len);
    rd_ok      = rd_active && (rd_space >= rd_len);
    rd_low     = rd_cnt < ADDR_W'(RD_LOW_WM);
    ref_ok     = pending != 4'd0;
    ref_urgent = pending >= 4'(REF_URGENT);
  end

  // Next state and arbitration.
  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    grant_op = OP_WR;
    case (state)
      IDLE: begin
        if (init_done) begin
          grant = 1'b1;
          if (ref_urgent)              grant_op = OP_REF;
          else if (rd_ok && rd_low)    grant_op = OP_RD;
          else if (rd_ok && wr_ok)     grant_op = last_rd ? OP_WR : OP_RD;
          else if (rd_ok)              grant_op = OP_RD;
          else if (wr_ok)              grant_op = OP_WR;
          else if (ref_ok)             grant_op = OP_REF;
          else                         grant    = 1'b0;
        end
        if (grant) state_n = ISSUE;
      end
      ISSUE:   if (hs) state_n = WAIT;
      WAIT:    if (burst_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sdram or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Registered command outputs, latched at the decision.
  always_ff @(posedge clk_sdram or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      op_q      <= OP_WR;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      last_rd   <= 1'b0;
    end else begin
      cmd_valid <= (state_n == ISSUE);
      busy      <= (state_n != IDLE);
      if (grant) begin
        op_q <= grant_op;
        case (grant_op)
          OP_WR:   begin cmd_addr <= wr_cur; cmd_len <= LEN_W'(wr_len); end
          OP_RD:   begin cmd_addr <= rd_cur; cmd_len <= LEN_W'(rd_len); end
          default: begin cmd_addr <= '0;     cmd_len <= '0;             end
        endcase
        if (grant_op != OP_REF) last_rd <= (grant_op == OP_RD);
      end
    end
  end

  assign ref_tick = init_done && (ref_cnt == CNT_LAST);

  // Refresh interval timer and saturating pending count.
  always_ff @(posedge clk_sdram or posedge rst) begin
    if (rst) begin
      ref_cnt      <= '0;
      pending      <= '0;
      ref_overflow <= 1'b0;
    end else begin
      if (!init_done || ref_tick) ref_cnt <= '0;
      else                        ref_cnt <= ref_cnt + CNT_W'(1);
      case ({ref_tick, hs && (op_q == OP_REF)})
        2'b10: begin
          if (pending != PEND_MAX) pending <= pending + 4'd1;
          if (pending >= PEND_MAX - 4'd1) ref_overflow <= 1'b1;
        end
        2'b01:   pending <= pending - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Directed self-checking bench for sdram_burst_sched with a hand-driven
// burst engine: each command is accepted, then burst_done is pulsed.
module tb_sdram_burst_sched;

  logic        clk_sdram = 1'b0;
  logic        rst, init_done;
  logic        wr_load, rd_load;
  logic [23:0] wr_addr, wr_length, rd_addr, rd_length;
  logic [9:0]  wr_fifo_cnt, rd_fifo_cnt;
  logic        cmd_valid, cmd_ready, burst_done;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        wr_done, rd_done, busy, ref_overflow;

  int n_assert = 0;
  int n_fail   = 0;
  logic wd, rdd;

  always #5 clk_sdram = ~clk_sdram;

  sdram_burst_sched dut (
    .clk_sdram(clk_sdram), .rst(rst), .init_done(init_done),
    .wr_load(wr_load), .wr_addr(wr_addr), .wr_length(wr_length),
    .wr_fifo_cnt(wr_fifo_cnt), .rd_load(rd_load), .rd_addr(rd_addr),
    .rd_length(rd_length), .rd_fifo_cnt(rd_fifo_cnt), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .burst_done(burst_done), .wr_done(wr_done),
    .rd_done(rd_done), .busy(busy), .ref_overflow(ref_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_ready = 1'b0; burst_done = 1'b0;
    wr_load = 1'b0; rd_load = 1'b0;
    repeat (2) @(negedge clk_sdram);
    rst = 1'b0;
    @(negedge clk_sdram);
  endtask

  task automatic pulse_wr(input logic [23:0] a, input logic [23:0] l);
    wr_addr = a; wr_length = l; wr_load = 1'b1;
    @(negedge clk_sdram);
    wr_load = 1'b0;
  endtask

  // Wait (bounded) for a command, check it, and accept it.
  task automatic issue_check(input string tag, input logic [1:0] op,
                             input logic [23:0] a, input logic [8:0] l);
    int k = 0;
    while (!cmd_valid && k < 60) begin @(negedge clk_sdram); k++; end
    chk({tag, " valid"}, 32'(cmd_valid), 32'd1);
    chk({tag, " op"},    32'(cmd_op),    32'(op));
    chk({tag, " addr"},  32'(cmd_addr),  32'(a));
    chk({tag, " len"},   32'(cmd_len),   32'(l));
    cmd_ready = 1'b1;
    @(negedge clk_sdram);
    cmd_ready = 1'b0;
  endtask

  // Complete the accepted burst and sample the done pulses one cycle later.
  task automatic finish_burst(output logic w, output logic r);
    burst_done = 1'b1;
    @(negedge clk_sdram);
    burst_done = 1'b0;
    w = wr_done; r = rd_done;
  endtask

  task automatic expect_cmd(input string tag, input logic [1:0] op,
                            input logic [23:0] a, input logic [8:0] l,
                            input logic exp_wd, input logic exp_rd);
    logic w, r;
    issue_check(tag, op, a, l);
    finish_burst(w, r);
    chk({tag, " wr_done"}, 32'(w), 32'(exp_wd));
    chk({tag, " rd_done"}, 32'(r), 32'(exp_rd));
  endtask

  initial begin
    init_done = 1'b0; wr_addr = '0; wr_length = '0; rd_addr = '0; rd_length = '0;
    wr_fifo_cnt = '0; rd_fifo_cnt = '0;

    // Reset values
    rst = 1'b1; cmd_ready = 1'b0; burst_done = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
    repeat (2) @(negedge clk_sdram);
    chk("rst cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cmd_op", 32'(cmd_op), 32'd0);
    chk("rst cmd_addr", 32'(cmd_addr), 32'd0);
    chk("rst cmd_len", 32'(cmd_len), 32'd0);
    chk("rst dones", 32'({wr_done, rd_done}), 32'd0);
    chk("rst ref_overflow", 32'(ref_overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk_sdram);

    // No grants before init_done, then the write split across boundaries
    wr_fifo_cnt = 10'd512;
    pulse_wr(24'h0000F0, 24'd600);
    repeat (10) @(negedge clk_sdram);
    chk("no init no grant", 32'(cmd_valid), 32'd0);
    init_done = 1'b1;
    expect_cmd("split0", 2'd0, 24'h0000F0, 9'd16,  1'b0, 1'b0);
    expect_cmd("split1", 2'd0, 24'h000100, 9'd256, 1'b0, 1'b0);
    expect_cmd("split2", 2'd0, 24'h000200, 9'd256, 1'b0, 1'b0);
    expect_cmd("split3", 2'd0, 24'h000300, 9'd72,  1'b1, 1'b0);
    @(negedge clk_sdram);
    chk("split done one-shot", 32'(wr_done), 32'd0);

    // Zero length load pulses done without any command
    pulse_wr(24'h001234, 24'd0);
    chk("zero-len wr_done", 32'(wr_done), 32'd1);
    @(negedge clk_sdram);
    chk("zero-len done drop", 32'(wr_done), 32'd0);
    repeat (5) @(negedge clk_sdram);
    chk("zero-len no cmd", 32'(cmd_valid), 32'd0);

    // Read below the low watermark beats an eligible write
    do_reset();
    wr_fifo_cnt = 10'd512; rd_fifo_cnt = 10'd100;
    wr_addr = 24'h000000; wr_length = 24'd512; wr_load = 1'b1;
    rd_addr = 24'h001000; rd_length = 24'd512; rd_load = 1'b1;
    @(negedge clk_sdram);
    wr_load = 1'b0; rd_load = 1'b0;
    expect_cmd("lowwm rd0", 2'd1, 24'h001000, 9'd256, 1'b0, 1'b0);
    expect_cmd("lowwm rd1", 2'd1, 24'h001100, 9'd256, 1'b0, 1'b1);
    expect_cmd("lowwm wr0", 2'd0, 24'h000000, 9'd256, 1'b0, 1'b0);
    expect_cmd("lowwm wr1", 2'd0, 24'h000100, 9'd256, 1'b1, 1'b0);

    // Round-robin: write granted alone first, then read and write alternate
    do_reset();
    wr_fifo_cnt = 10'd512; rd_fifo_cnt = 10'd200;
    pulse_wr(24'h000000, 24'd512);
    rd_addr = 24'h003000; rd_length = 24'd512; rd_load = 1'b1;
    @(negedge clk_sdram);
    rd_load = 1'b0;
    expect_cmd("rr wr0", 2'd0, 24'h000000, 9'd256, 1'b0, 1'b0);
    expect_cmd("rr rd0", 2'd1, 24'h003000, 9'd256, 1'b0, 1'b0);
    expect_cmd("rr wr1", 2'd0, 24'h000100, 9'd256, 1'b1, 1'b0);
    expect_cmd("rr rd1", 2'd1, 24'h003100, 9'd256, 1'b0, 1'b1);

    // Read gated by free space in the read FIFO
    do_reset();
    rd_fifo_cnt = 10'd400;
    rd_addr = 24'h000000; rd_length = 24'd256; rd_load = 1'b1;
    @(negedge clk_sdram);
    rd_load = 1'b0;
    repeat (20) @(negedge clk_sdram);
    chk("gate 400 no grant", 32'(cmd_valid), 32'd0);
    rd_fifo_cnt = 10'd257;
    repeat (5) @(negedge clk_sdram);
    chk("gate 257 no grant", 32'(cmd_valid), 32'd0);
    rd_fifo_cnt = 10'd256;
    expect_cmd("gate 256", 2'd1, 24'h000000, 9'd256, 1'b0, 1'b1);

    // Abort: reload while the last write burst is in flight
    do_reset();
    wr_fifo_cnt = 10'd512;
    pulse_wr(24'h000000, 24'd256);
    issue_check("abort old", 2'd0, 24'h000000, 9'd256);
    chk("abort in wait busy", 32'(busy), 32'd1);
    pulse_wr(24'h005000, 24'd1024);
    finish_burst(wd, rdd);
    chk("abort no wr_done", 32'(wd), 32'd0);
    expect_cmd("abort new", 2'd0, 24'h005000, 9'd256, 1'b0, 1'b0);

    // Reset asserted in ISSUE clears outputs at once
    do_reset();
    pulse_wr(24'h000000, 24'd256);
    repeat (2) @(negedge clk_sdram);
    chk("issue before rst", 32'(cmd_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst in issue valid", 32'(cmd_valid), 32'd0);
    chk("rst in issue busy", 32'(busy), 32'd0);
    @(negedge clk_sdram);
    rst = 1'b0;
    repeat (20) @(negedge clk_sdram);
    chk("after rst idle", 32'(cmd_valid), 32'd0);

    // Refresh urgency: five intervals stalled, refresh drains to below 4
    do_reset();
    repeat (1000) @(negedge clk_sdram);
    pulse_wr(24'h000000, 24'd256);
    repeat (2950) @(negedge clk_sdram);
    chk("urgent no overflow", 32'(ref_overflow), 32'd0);
    expect_cmd("urgent ref0", 2'd2, 24'h000000, 9'd0, 1'b0, 1'b0);
    expect_cmd("urgent ref1", 2'd2, 24'h000000, 9'd0, 1'b0, 1'b0);
    expect_cmd("urgent wr", 2'd0, 24'h000000, 9'd256, 1'b1, 1'b0);

    // Nine stalled intervals saturate pending and set the sticky flag
    do_reset();
    repeat (9 * 780 + 50) @(negedge clk_sdram);
    chk("overflow set", 32'(ref_overflow), 32'd1);
    chk("overflow ref pending", 32'(cmd_op), 32'd2);
    do_reset();
    chk("overflow cleared by rst", 32'(ref_overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
